comp_serial_nb: RTL



---
 rtl/comp_serial_nb.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/comp_serial_nb.sv
`default_nettype none
// ============================================================================
// Module      : comp_serial_nb
// Description : Digit-serial magnitude comparator. It compares two WIDTH-bit
//               operands DIGIT bits per clock, starting with the MSB digit.
//               Latency is fixed at WIDTH/DIGIT cycles. The result is a
//               registered A>B / B>A / A==B decision, with an optional
//               two's-complement ordering.
// Revision    : 1.0 - initial release
// ============================================================================
module comp_serial_nb #(
    parameter int WIDTH  = 32,
    parameter int DIGIT  = 2,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             A_big,
    output logic             B_big,
    output logic             equal
);

    // Number of digit steps and the counter width needed to hold 0..N.
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N + 1) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             decided_q, decided_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;
    logic             done_q, done_d;
    logic             a_big_q, a_big_d;
    logic             b_big_q, b_big_d;
    logic             equal_q, equal_d;

    logic [DIGIT-1:0] w_flip;
    logic [DIGIT-1:0] w_da;
    logic [DIGIT-1:0] w_db;
    logic             w_dig_gt;
    logic             w_dig_lt;
    logic             w_gt_final;
    logic             w_lt_final;
    logic             w_last_dig;

    // Digit compare of the current MSB digits. In signed mode the sign bit
    // of the first digit is inverted, which maps two's-complement order
    // onto unsigned order. Earlier decisions are sticky.
    always_comb begin
        w_flip = '0;
        if ((SIGNED != 0) && (cnt_q == '0)) begin
            w_flip[DIGIT-1] = 1'b1;
        end
        w_da       = sa_q[WIDTH-1 -: DIGIT] ^ w_flip;
        w_db       = sb_q[WIDTH-1 -: DIGIT] ^ w_flip;
        w_dig_gt   = (w_da > w_db);
        w_dig_lt   = (w_da < w_db);
        w_gt_final = decided_q ? gt_q : w_dig_gt;
        w_lt_final = decided_q ? lt_q : w_dig_lt;
        w_last_dig = (cnt_q == LAST_CNT);
    end

    // Next-state logic: operand capture in IDLE, one digit per cycle in RUN.
    // Results are published only on the last digit edge.
    always_comb begin
        state_d   = state_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        cnt_d     = cnt_q;
        decided_d = decided_q;
        gt_d      = gt_q;
        lt_d      = lt_q;
        done_d    = 1'b0;
        a_big_d   = a_big_q;
        b_big_d   = b_big_q;
        equal_d   = equal_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_RUN;
                    sa_d      = A;
                    sb_d      = B;
                    cnt_d     = '0;
                    decided_d = 1'b0;
                    gt_d      = 1'b0;
                    lt_d      = 1'b0;
                end
            end
            S_RUN: begin
                decided_d = decided_q | w_dig_gt | w_dig_lt;
                gt_d      = w_gt_final;
                lt_d      = w_lt_final;
                sa_d      = sa_q << DIGIT;
                sb_d      = sb_q << DIGIT;
                cnt_d     = cnt_q + 1'b1;
                if (w_last_dig) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    a_big_d = w_gt_final;
                    b_big_d = w_lt_final;
                    equal_d = ~(w_gt_final | w_lt_final);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            sa_q      <= '0;
            sb_q      <= '0;
            cnt_q     <= '0;
            decided_q <= 1'b0;
            gt_q      <= 1'b0;
            lt_q      <= 1'b0;
            done_q    <= 1'b0;
            a_big_q   <= 1'b0;
            b_big_q   <= 1'b0;
            equal_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sa_q      <= sa_d;
            sb_q      <= sb_d;
            cnt_q     <= cnt_d;
            decided_q <= decided_d;
            gt_q      <= gt_d;
            lt_q      <= lt_d;
            done_q    <= done_d;
            a_big_q   <= a_big_d;
            b_big_q   <= b_big_d;
            equal_q   <= equal_d;
        end
    end

    assign busy  = (state_q == S_RUN);
    assign done  = done_q;
    assign A_big = a_big_q;
    assign B_big = b_big_q;
    assign equal = equal_q;

endmodule
`default_nettype wire
